life_tone_seq: RTL and testbench

LIFE_TONE_SEQ -- requirements
Module: life_tone_seq

---
 rtl/tone_pkg.sv | 76 +++++++
 rtl/tone_timer.sv | 32 +++
 rtl/life_tone_seq.sv | 153 +++++++++++++++
 tb/tb_life_tone_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
`default_nettype none
// ============================================================================
// tone_pkg : note set, divisor helper, jingle ROMs and FSM state for life_tone_seq
// Rev 1.0
// ============================================================================
package tone_pkg;

    localparam int CNT_W = 32;
    localparam int DIV_W = 22;
    localparam int IDX_W = 2;

    typedef enum logic [2:0] {
        NOTE_SIL = 3'd0,
        NOTE_C4  = 3'd1,
        NOTE_D4  = 3'd2,
        NOTE_E4  = 3'd3,
        NOTE_G4  = 3'd4,
        NOTE_C5  = 3'd5,
        NOTE_E5  = 3'd6,
        NOTE_G5  = 3'd7
    } note_e;

    localparam int FREQ_C4 = 262;
    localparam int FREQ_D4 = 294;
    localparam int FREQ_E4 = 330;
    localparam int FREQ_G4 = 392;
    localparam int FREQ_C5 = 523;
    localparam int FREQ_E5 = 659;
    localparam int FREQ_G5 = 784;

    typedef enum logic [1:0] {
        JG_OVER = 2'd0,
        JG_UP   = 2'd1,
        JG_DOWN = 2'd2
    } jingle_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    function automatic int note_freq(input note_e n);
        case (n)
            NOTE_C4: return FREQ_C4;
            NOTE_D4: return FREQ_D4;
            NOTE_E4: return FREQ_E4;
            NOTE_G4: return FREQ_G4;
            NOTE_C5: return FREQ_C5;
            NOTE_E5: return FREQ_E5;
            NOTE_G5: return FREQ_G5;
            default: return 1;
        endcase
    endfunction

    // Silence is divisor 1; the external generator pairs it with volume 0.
    function automatic logic [DIV_W-1:0] note_div(input int clk_hz, input note_e n);
        if (n == NOTE_SIL) return DIV_W'(1);
        return DIV_W'((clk_hz / 2) / note_freq(n));
    endfunction

    function automatic logic [2:0] jingle_len(input jingle_e j);
        return (j == JG_OVER) ? 3'd4 : 3'd3;
    endfunction

    function automatic note_e jingle_note(input jingle_e j, input logic [IDX_W-1:0] i);
        case (j)
            JG_OVER: return (i == 2'd0) ? NOTE_G4 : (i == 2'd1) ? NOTE_E4 : NOTE_C4;
            JG_UP:   return (i == 2'd0) ? NOTE_C5 : (i == 2'd1) ? NOTE_E5 : NOTE_G5;
            JG_DOWN: return (i == 2'd0) ? NOTE_E4 : (i == 2'd1) ? NOTE_D4 : NOTE_C4;
            default: return NOTE_SIL;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/tone_timer.sv
`default_nettype none
// ============================================================================
// tone_timer : loadable down-counter; done is high on the last counted cycle
// Rev 1.0
// ============================================================================
module tone_timer
    import tone_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // A load of N yields done on the Nth cycle after the load edge.
    assign done = (r_count == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/life_tone_seq.sv
`default_nettype none
// ============================================================================
// life_tone_seq : plays a short jingle on every life change, else a sustain tone
// Rev 1.0
// ============================================================================
module life_tone_seq
    import tone_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int LIFE_W  = 3,
    parameter int NOTE_MS = 120,
    parameter int GAP_MS  = 20,
    parameter int VOL     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LIFE_W-1:0] life,
    input  logic              sustain_en,
    output logic [21:0]       note_div_left,
    output logic [21:0]       note_div_right,
    output logic [2:0]        volume,
    output logic              busy
);

    localparam int NOTE_RAW = CLK_HZ / 1000 * NOTE_MS;
    localparam int GAP_RAW  = CLK_HZ / 1000 * GAP_MS;
    localparam logic [CNT_W-1:0] NOTE_CYC = (NOTE_RAW < 1) ? CNT_W'(1) : CNT_W'(NOTE_RAW);
    localparam logic [CNT_W-1:0] GAP_CYC  = (GAP_RAW < 1) ? '0 : CNT_W'(GAP_RAW);
    localparam logic [2:0]       VOL_L    = 3'(VOL);

    localparam logic [DIV_W-1:0] DIV_TAB [8] = '{
        note_div(CLK_HZ, NOTE_SIL), note_div(CLK_HZ, NOTE_C4),
        note_div(CLK_HZ, NOTE_D4),  note_div(CLK_HZ, NOTE_E4),
        note_div(CLK_HZ, NOTE_G4),  note_div(CLK_HZ, NOTE_C5),
        note_div(CLK_HZ, NOTE_E5),  note_div(CLK_HZ, NOTE_G5)
    };

    function automatic note_e sustain_note(input logic [LIFE_W-1:0] l);
        int unsigned v;
        v = 32'(l);
        if (v == 0) return NOTE_SIL;
        if (v == 1) return NOTE_C4;
        if (v == 2) return NOTE_D4;
        if (v == 3) return NOTE_E4;
        return NOTE_G4;
    endfunction

    logic [LIFE_W-1:0] r_life_q;
    state_e            r_state, w_state_n;
    jingle_e           r_jingle, w_jingle_n, w_cls;
    logic [IDX_W-1:0]  r_idx, w_idx_n;
    logic              w_event, w_last, w_done, w_load;
    logic [CNT_W-1:0]  w_load_val;
    note_e             w_note;
    logic [2:0]        w_vol;
    logic              w_busy;

    // Reset also captures life, so releasing reset never fires a jingle.
    always_ff @(posedge clk) begin
        r_life_q <= life;
    end

    assign w_event = (life != r_life_q);
    assign w_cls   = (life == '0) ? JG_OVER : (life > r_life_q) ? JG_UP : JG_DOWN;
    assign w_last  = ({1'b0, r_idx} == (jingle_len(r_jingle) - 3'd1));

    tone_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .done     (w_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_jingle <= JG_DOWN;
            r_idx    <= '0;
        end else begin
            r_state  <= w_state_n;
            r_jingle <= w_jingle_n;
            r_idx    <= w_idx_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_jingle_n = r_jingle;
        w_idx_n    = r_idx;
        w_load     = 1'b0;
        w_load_val = '0;
        if (w_event) begin
            w_state_n  = ST_PLAY;
            w_jingle_n = w_cls;
            w_idx_n    = '0;
            w_load     = 1'b1;
            w_load_val = NOTE_CYC;
        end else if (w_done && (r_state != ST_IDLE)) begin
            // A zero-length gap goes straight on to the next note.
            if (r_state == ST_PLAY && GAP_CYC != '0) begin
                w_state_n  = ST_GAP;
                w_load     = 1'b1;
                w_load_val = GAP_CYC;
            end else if (w_last) begin
                w_state_n  = ST_IDLE;
            end else begin
                w_state_n  = ST_PLAY;
                w_idx_n    = r_idx + IDX_W'(1);
                w_load     = 1'b1;
                w_load_val = NOTE_CYC;
            end
        end
    end

    always_comb begin
        w_note = NOTE_SIL;
        w_vol  = '0;
        w_busy = 1'b0;
        case (r_state)
            ST_PLAY: begin
                w_note = jingle_note(r_jingle, r_idx);
                w_vol  = VOL_L;
                w_busy = 1'b1;
            end
            ST_GAP: begin
                w_busy = 1'b1;
            end
            default: begin
                if (sustain_en) begin
                    w_note = sustain_note(r_life_q);
                    if (w_note != NOTE_SIL) w_vol = VOL_L;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            note_div_left  <= 22'd1;
            note_div_right <= 22'd1;
            volume         <= 3'd0;
            busy           <= 1'b0;
        end else begin
            note_div_left  <= DIV_TAB[w_note];
            note_div_right <= DIV_TAB[w_note];
            volume         <= w_vol;
            busy           <= w_busy;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_life_tone_seq.sv
`default_nettype none
// ============================================================================
// tb_life_tone_seq : directed scoreboard bench for life_tone_seq at CLK_HZ=10k
// Rev 1.0
// ============================================================================
module tb_life_tone_seq;

    // (CLK_HZ/2)/freq with CLK_HZ = 10_000
    localparam logic [21:0] D_SIL = 22'd1;
    localparam logic [21:0] D_C4  = 22'd19;
    localparam logic [21:0] D_D4  = 22'd17;
    localparam logic [21:0] D_E4  = 22'd15;
    localparam logic [21:0] D_G4  = 22'd12;
    localparam logic [21:0] D_C5  = 22'd9;
    localparam logic [21:0] D_E5  = 22'd7;
    localparam logic [21:0] D_G5  = 22'd6;
    localparam logic [2:0]  V_ON  = 3'd3;
    localparam int          PHASE = 10;

    typedef struct packed {
        logic [21:0] dl;
        logic [21:0] dr;
        logic [2:0]  vol;
        logic        busy;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  life;
    logic        sustain_en;
    logic [21:0] note_div_left;
    logic [21:0] note_div_right;
    logic [2:0]  volume;
    logic        busy;

    obs_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    life_tone_seq #(
        .CLK_HZ  (10_000),
        .LIFE_W  (3),
        .NOTE_MS (1),
        .GAP_MS  (1),
        .VOL     (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .life           (life),
        .sustain_en     (sustain_en),
        .note_div_left  (note_div_left),
        .note_div_right (note_div_right),
        .volume         (volume),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [21:0] d, input logic [2:0] v, input logic b, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({d, d, v, b});
    endtask

    // Each note sounds for PHASE cycles followed by a PHASE-cycle silent gap.
    task automatic push_jingle(input logic [21:0] n0, input logic [21:0] n1,
                               input logic [21:0] n2, input logic [21:0] n3, input int len);
        logic [21:0] notes [4];
        notes = '{n0, n1, n2, n3};
        for (int k = 0; k < len; k++) begin
            push(notes[k], V_ON, 1'b1, PHASE);
            push(D_SIL, 3'd0, 1'b1, PHASE);
        end
    endtask

    task automatic check_one(input string tag);
        obs_t e;
        obs_t o;
        e = exp_q.pop_front();
        o = {note_div_left, note_div_right, volume, busy};
        n_total++;
        assert (o === e) n_pass++;
        else $error("FAIL %s #%0d: observed dl=%0d dr=%0d vol=%0d busy=%0b expected dl=%0d dr=%0d vol=%0d busy=%0b",
                    tag, n_total, o.dl, o.dr, o.vol, o.busy, e.dl, e.dr, e.vol, e.busy);
    endtask

    // Samples on the falling edge; inputs are changed by the caller right after.
    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_one(tag);
        end
    endtask

    task automatic run_all(input string tag);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            check_one(tag);
        end
    endtask

    initial begin
        rst        = 1'b0;
        life       = 3'd3;
        sustain_en = 1'b0;

        push(D_SIL, 3'd0, 1'b0, 3);
        run_all("reset");
        rst = 1'b1;
        push(D_SIL, 3'd0, 1'b0, 6);
        run_all("release_no_jingle");

        sustain_en = 1'b1;
        push(D_E4, V_ON, 1'b0, 4);
        run_all("sustain_on_life3");

        // DOWN jingle interrupted in its first gap by an OVER event.
        life = 3'd2;
        push(D_E4, V_ON, 1'b0, 1);
        push(D_E4, V_ON, 1'b1, PHASE);
        push(D_SIL, 3'd0, 1'b1, 4);
        run_all("down_start");
        life = 3'd0;
        push(D_SIL, 3'd0, 1'b1, 1);
        push_jingle(D_G4, D_E4, D_C4, D_C4, 4);
        push(D_SIL, 3'd0, 1'b0, 5);
        run_all("restart_over");

        life = 3'd2;
        push(D_SIL, 3'd0, 1'b0, 1);
        push_jingle(D_C5, D_E5, D_G5, D_SIL, 3);
        push(D_D4, V_ON, 1'b0, 4);
        run_all("up_0_2");

        sustain_en = 1'b0;
        push(D_SIL, 3'd0, 1'b0, 3);
        run_all("sustain_off_life2");
        sustain_en = 1'b1;
        push(D_D4, V_ON, 1'b0, 3);
        run_all("sustain_on_life2");

        life = 3'd3;
        push(D_D4, V_ON, 1'b0, 1);
        push_jingle(D_C5, D_E5, D_G5, D_SIL, 3);
        push(D_E4, V_ON, 1'b0, 4);
        run_all("up_2_3");

        // Reset in the middle of a DOWN note, released with life unchanged.
        life = 3'd1;
        push(D_E4, V_ON, 1'b0, 1);
        push(D_E4, V_ON, 1'b1, 5);
        run_all("down_before_reset");
        rst = 1'b0;
        push(D_SIL, 3'd0, 1'b0, 2);
        run_all("mid_jingle_reset");
        rst = 1'b1;
        push(D_C4, V_ON, 1'b0, 5);
        run_all("reset_release_idle");

        life = 3'd0;
        push(D_C4, V_ON, 1'b0, 1);
        push_jingle(D_G4, D_E4, D_C4, D_C4, 4);
        push(D_SIL, 3'd0, 1'b0, 5);
        run_all("over_1_0");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
